// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding,
// default widths and the request legality check.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 9;
    localparam int unsigned LSU_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StResp = 2'd3
    } lsu_state_e;

    // 1 when the request is misaligned or its funct3 is not legal for its direction.
    function automatic logic lsu_req_err(input logic store, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = store;
            F3_HU:   err = store | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; master is the core/memory side.
interface lsu_if #(
    parameter int unsigned ADDR_W = lsu_pkg::LSU_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends the addressed byte/halfword of a
// memory word for loads, and merges store data into a word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = word;
        endcase

        // Only SB/SH reach the merge path, so funct3[0] separates halfword from byte.
        merged = word;
        if (funct3[0]) begin
            if (addr_lo[1]) merged[31:16] = wdata;
            else            merged[15:0]  = wdata;
        end else begin
            case (addr_lo)
                2'd0: merged[7:0]   = wdata[7:0];
                2'd1: merged[15:8]  = wdata[7:0];
                2'd2: merged[23:16] = wdata[7:0];
                2'd3: merged[31:24] = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, fixed latency, registered outputs.
// Sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);

    lsu_state_e        state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        addr_lo_q;
    logic              store_q;
    logic [15:0]       wdata_q;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    assign accept  = bus.req_valid && bus.req_ready;
    assign req_err = lsu_req_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_lo_q),
        .word      (bus.mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            funct3_q       <= '0;
            addr_lo_q      <= '0;
            store_q        <= 1'b0;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        funct3_q      <= bus.req_funct3;
                        addr_lo_q     <= bus.req_addr[1:0];
                        store_q       <= bus.req_store;
                        wdata_q       <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        if (req_err) begin
                            state_q        <= StResp;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                        end else begin
                            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_store && bus.req_funct3 == F3_W) begin
                                state_q       <= StWr;
                                bus.mem_write <= 1'b1;
                                bus.mem_wdata <= bus.req_wdata;
                            end else begin
                                state_q      <= StRd;
                                bus.mem_read <= 1'b1;
                            end
                        end
                    end
                end
                StRd: begin
                    bus.mem_read <= 1'b0;
                    if (store_q) begin
                        state_q       <= StWr;
                        bus.mem_write <= 1'b1;
                        bus.mem_wdata <= merged;
                    end else begin
                        state_q        <= StResp;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= load_data;
                    end
                end
                StWr: begin
                    state_q        <= StResp;
                    bus.mem_write  <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= '0;
                end
                StResp: begin
                    state_q        <= StIdle;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.req_ready  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
